// File: rtl/ac_char_feeder.sv
// Aho-Corasick text feeder: byte FIFO, 4-bit char encode, position tracking.
// Define AC_CASE_FOLD_EN to map 'A'..'O' onto the same codes as 'a'..'o'.
module ac_char_feeder #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int POS_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  input  logic [7:0]        IN_DATA,
  input  logic              IN_LAST,
  output logic              IN_READY,
  output logic              CHARA_EN,
  output logic [3:0]        CHARA_OUT,
  output logic [POS_W-1:0]  CHARA_POS,
  output logic              CHARA_LAST,
  input  logic              CHARA_ACK,
  output logic              TEXT_DONE,
  output logic [ADDR_W:0]   FIFO_LEVEL
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

  state_e            state_q;
  logic              done_q;
  logic              live_q;
  logic [4:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   cnt_d;
  logic [POS_W-1:0]  pos_q;

  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  logic       head_last;
  logic [3:0] enc;

  // Letters in both ranges share their low nibble with the code.
  function automatic logic [3:0] encode(input logic [7:0] b);
    logic [3:0] c;
    c = 4'd0;
    if (b >= 8'h61 && b <= 8'h6f) c = b[3:0];
`ifdef AC_CASE_FOLD_EN
    if (b >= 8'h41 && b <= 8'h4f) c = b[3:0];
`endif
    return c;
  endfunction

  assign enc       = encode(IN_DATA);
  assign full      = (cnt_q == FULL_LVL);
  assign empty     = (cnt_q == '0);
  assign IN_READY  = live_q & ~full & (state_q != DRAIN);
  assign push      = IN_VALID & IN_READY;
  assign pop       = CHARA_ACK & ~empty;
  assign head_last = mem_q[rd_ptr_q][4];

  assign CHARA_EN   = ~empty;
  assign CHARA_OUT  = empty ? 4'd0 : mem_q[rd_ptr_q][3:0];
  assign CHARA_LAST = ~empty & head_last;
  assign CHARA_POS  = empty ? '0 : pos_q;
  assign FIFO_LEVEL = cnt_q;
  assign TEXT_DONE  = done_q;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= {IN_LAST, enc};
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      pos_q    <= '0;
      live_q   <= 1'b0;
    end else begin
      live_q <= 1'b1;
      cnt_q  <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        pos_q    <= head_last ? '0 : pos_q + POS_W'(1);
      end
    end
  end

  // A push during DONE starts the next text without losing it.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE, RUN: begin
          if (push && IN_LAST) state_q <= DRAIN;
          else if (push)       state_q <= RUN;
        end
        DRAIN: begin
          if (pop && head_last) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          if (push && IN_LAST) state_q <= DRAIN;
          else if (push)       state_q <= RUN;
          else                 state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ac_char_feeder.sv
// Scoreboard bench for ac_char_feeder.
// Expected chars queued on accepted push, checked on pop.
module tb_ac_char_feeder;

  logic        CLK;
  logic        RST;
  logic        IN_VALID;
  logic [7:0]  IN_DATA;
  logic        IN_LAST;
  logic        IN_READY;
  logic        CHARA_EN;
  logic [3:0]  CHARA_OUT;
  logic [15:0] CHARA_POS;
  logic        CHARA_LAST;
  logic        CHARA_ACK;
  logic        TEXT_DONE;
  logic [3:0]  FIFO_LEVEL;

  ac_char_feeder dut (
    .CLK        (CLK),
    .RST        (RST),
    .IN_VALID   (IN_VALID),
    .IN_DATA    (IN_DATA),
    .IN_LAST    (IN_LAST),
    .IN_READY   (IN_READY),
    .CHARA_EN   (CHARA_EN),
    .CHARA_OUT  (CHARA_OUT),
    .CHARA_POS  (CHARA_POS),
    .CHARA_LAST (CHARA_LAST),
    .CHARA_ACK  (CHARA_ACK),
    .TEXT_DONE  (TEXT_DONE),
    .FIFO_LEVEL (FIFO_LEVEL)
  );

  typedef struct packed {
    logic        last;
    logic [3:0]  code;
    logic [15:0] pos;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_pop_cyc = -10;
  int   exp_pos = 0;
  bit   prev_done = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] enc_model(input logic [7:0] b);
    int v;
    v = int'(b);
    if (v >= 97 && v <= 111) return 4'(v - 96);
`ifdef AC_CASE_FOLD_EN
    if (v >= 65 && v <= 79) return 4'(v - 64);
`endif
    return 4'd0;
  endfunction

  always @(negedge CLK) begin
    exp_t e;
    if (!RST) begin
      sb.delete();
      exp_pos   = 0;
      prev_done = 0;
    end else begin
      if (CHARA_EN && CHARA_ACK) begin
        if (sb.size() == 0) chk("sb_under", 1, 0);
        else begin
          e = sb.pop_front();
          chk("out", 32'(CHARA_OUT), 32'(e.code));
          chk("last", 32'(CHARA_LAST), 32'(e.last));
          chk("pos", 32'(CHARA_POS), 32'(e.pos));
          if (e.last) last_pop_cyc = cyc;
        end
      end
      if (!CHARA_EN) chk("pos_idle", 32'(CHARA_POS), 0);
      if (prev_done) chk("done_pulse", 32'(TEXT_DONE), 0);
      if (TEXT_DONE) chk("done_lat", cyc, last_pop_cyc + 1);
      prev_done = TEXT_DONE;
      if (IN_VALID && IN_READY) begin
        sb.push_back('{IN_LAST, enc_model(IN_DATA), 16'(exp_pos)});
        exp_pos = IN_LAST ? 0 : exp_pos + 1;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d, input logic l);
    bit ok;
    ok = 0;
    IN_VALID = 1'b1;
    IN_DATA  = d;
    IN_LAST  = l;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge CLK);
      ok = IN_READY;
      tick();
    end
    IN_VALID = 1'b0;
    IN_LAST  = 1'b0;
    if (!ok) chk("push_timeout", 0, 1);
  endtask

  task automatic wait_done();
    bit got;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge CLK);
      got = TEXT_DONE;
    end
    chk("text_done", 32'(got), 1);
    tick();
  endtask

  initial begin
    logic [7:0] t3 [9];
    t3 = '{8'h70, 8'h7a, 8'h60, 8'h61, 8'h6f, 8'h41, 8'h4f, 8'h00, 8'hff};
    RST = 1'b0;
    IN_VALID = 1'b0;
    IN_DATA = 8'h00;
    IN_LAST = 1'b0;
    CHARA_ACK = 1'b0;

    // reset state
    #3;
    chk("rst_ready", 32'(IN_READY), 0);
    chk("rst_en", 32'(CHARA_EN), 0);
    chk("rst_level", 32'(FIFO_LEVEL), 0);
    chk("rst_done", 32'(TEXT_DONE), 0);
    chk("rst_pos", 32'(CHARA_POS), 0);
    repeat (2) tick();
    RST = 1'b1;
    @(negedge CLK);
    chk("ready_pre", 32'(IN_READY), 0);
    tick();
    chk("ready_rise", 32'(IN_READY), 1);

    // "abc" with ACK held
    CHARA_ACK = 1'b1;
    push_byte(8'h61, 1'b0);
    push_byte(8'h62, 1'b0);
    push_byte(8'h63, 1'b1);
    @(negedge CLK);
    chk("ready_drain", 32'(IN_READY), 0);
    wait_done();

    // fill to full, hold off the 9th byte
    CHARA_ACK = 1'b0;
    for (int i = 0; i < 8; i++) push_byte(8'(8'h61 + i), 1'b0);
    @(negedge CLK);
    chk("lvl_full", 32'(FIFO_LEVEL), 8);
    chk("rdy_full", 32'(IN_READY), 0);
    IN_VALID = 1'b1;
    IN_DATA  = 8'h69;
    IN_LAST  = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      chk("held_off", 32'(IN_READY), 0);
    end
    tick();
    CHARA_ACK = 1'b1;
    @(negedge CLK);
    chk("rdy_full_pop", 32'(IN_READY), 0);
    tick();
    CHARA_ACK = 1'b0;
    @(negedge CLK);
    chk("lvl_after_ack", 32'(FIFO_LEVEL), 7);
    chk("rdy_after_ack", 32'(IN_READY), 1);
    tick();
    IN_VALID = 1'b0;
    CHARA_ACK = 1'b1;
    push_byte(8'h6a, 1'b1);
    wait_done();

    // encoding boundaries
    for (int i = 0; i < 9; i++) push_byte(t3[i], 1'(i == 8));
    wait_done();

    // steady level 4 with push and pop every cycle
    CHARA_ACK = 1'b0;
    for (int i = 0; i < 4; i++) push_byte(8'(8'h6b + i), 1'b0);
    CHARA_ACK = 1'b1;
    IN_VALID  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      IN_DATA = 8'(8'h61 + (i % 15));
      IN_LAST = 1'b0;
      @(negedge CLK);
      chk("lvl_steady", 32'(FIFO_LEVEL), 4);
      tick();
    end
    IN_VALID = 1'b0;
    push_byte(8'h6f, 1'b1);
    wait_done();

    // hold 'e' for 5 cycles
    CHARA_ACK = 1'b0;
    push_byte(8'h64, 1'b0);
    push_byte(8'h65, 1'b1);
    CHARA_ACK = 1'b1;
    tick();
    CHARA_ACK = 1'b0;
    repeat (5) begin
      @(negedge CLK);
      chk("hold_en", 32'(CHARA_EN), 1);
      chk("hold_out", 32'(CHARA_OUT), 5);
      chk("hold_pos", 32'(CHARA_POS), 1);
    end
    tick();
    CHARA_ACK = 1'b1;
    @(negedge CLK);
    chk("hold_lvl", 32'(FIFO_LEVEL), 1);
    @(negedge CLK);
    chk("hold_done", 32'(TEXT_DONE), 1);
    tick();

    // reset mid-text
    CHARA_ACK = 1'b0;
    push_byte(8'h61, 1'b0);
    push_byte(8'h62, 1'b0);
    push_byte(8'h63, 1'b0);
    #2;
    RST = 1'b0;
    #1;
    chk("mid_rst_en", 32'(CHARA_EN), 0);
    chk("mid_rst_lvl", 32'(FIFO_LEVEL), 0);
    chk("mid_rst_rdy", 32'(IN_READY), 0);
    @(negedge CLK);
    tick();
    RST = 1'b1;
    tick();
    CHARA_ACK = 1'b1;
    push_byte(8'h62, 1'b0);
    push_byte(8'h63, 1'b1);
    wait_done();

    repeat (3) tick();
    chk("sb_empty", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
